// File: rtl/loopback_msg_arbiter_if.sv
// AXI-Stream bundle with LANES parallel channels; used for both the per-source
// ingress side (LANES=PORT_COUNT) and the single FIFO egress side (LANES=1).
interface loopback_msg_arbiter_if #(
  parameter int unsigned LANES      = 1,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned STRB_WIDTH = 8,
  parameter int unsigned DEST_WIDTH = 9
);
  logic [LANES*DATA_WIDTH-1:0] tdata;
  logic [LANES*STRB_WIDTH-1:0] tkeep;
  logic [LANES-1:0]            tvalid;
  logic [LANES-1:0]            tlast;
  logic [LANES*DEST_WIDTH-1:0] tdest;
  logic [LANES-1:0]            tready;

  modport master (output tdata, tkeep, tvalid, tlast, tdest, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tdest, output tready);
endinterface

// File: rtl/loopback_msg_arbiter.sv
// Frame-level round-robin arbiter feeding the loopback message FIFO: each granted
// frame goes out as one destination header beat followed by its (possibly truncated) payload.
module loopback_msg_arbiter #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned PORT_COUNT   = 4,
  parameter int unsigned SRC_WIDTH    = 2,
  parameter int unsigned CORE_WIDTH   = 4,
  parameter int unsigned ID_TAG_WIDTH = 5 + CORE_WIDTH,
  parameter int unsigned MAX_BEATS    = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  loopback_msg_arbiter_if.slave  s_axis,
  loopback_msg_arbiter_if.master m_axis,
  output logic                   busy,
  output logic [15:0]            trunc_count
);

  localparam int unsigned CNT_WIDTH  = 16;
  localparam int unsigned SRC_LSB    = DATA_WIDTH - 8;
  localparam logic [CNT_WIDTH-1:0] BEAT_LIMIT = CNT_WIDTH'(MAX_BEATS - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;

  state_t                  state;
  logic [SRC_WIDTH-1:0]    grant;
  logic [SRC_WIDTH-1:0]    last_grant;
  logic [ID_TAG_WIDTH-1:0] dest_lat;
  logic [CNT_WIDTH-1:0]    beat_cnt;

  logic [DATA_WIDTH-1:0]   m_data;
  logic [STRB_WIDTH-1:0]   m_keep;
  logic                    m_valid;
  logic                    m_last;

  logic                    load_ok;
  logic                    any_valid;
  logic [SRC_WIDTH-1:0]    grant_nxt;
  logic [SRC_WIDTH-1:0]    scan_idx;
  logic [ID_TAG_WIDTH-1:0] nxt_dest;
  logic                    g_valid;
  logic                    g_last;
  logic [DATA_WIDTH-1:0]   g_data;
  logic [STRB_WIDTH-1:0]   g_keep;
  logic [DATA_WIDTH-1:0]   hdr_data;
  logic [PORT_COUNT-1:0]   s_ready;

  assign load_ok = !m_valid || m_axis.tready;

  // Round-robin search: scan downwards so the nearest valid port after last_grant wins.
  always_comb begin
    any_valid = 1'b0;
    grant_nxt = last_grant;
    scan_idx  = '0;
    for (int i = int'(PORT_COUNT); i >= 1; i--) begin
      scan_idx = SRC_WIDTH'((int'(last_grant) + i) % int'(PORT_COUNT));
      if (s_axis.tvalid[scan_idx]) begin
        any_valid = 1'b1;
        grant_nxt = scan_idx;
      end
    end
  end

  assign nxt_dest = s_axis.tdest[int'(grant_nxt)*ID_TAG_WIDTH +: ID_TAG_WIDTH];
  assign g_valid  = s_axis.tvalid[grant];
  assign g_last   = s_axis.tlast[grant];
  assign g_data   = s_axis.tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign g_keep   = s_axis.tkeep[int'(grant)*STRB_WIDTH +: STRB_WIDTH];

  // Header: source index in the top byte, destination tag in the low bits.
  always_comb begin
    hdr_data = '0;
    hdr_data[SRC_LSB +: 8] = 8'(grant);
    hdr_data[ID_TAG_WIDTH-1:0] = dest_lat;
  end

  // Ingress ready follows the output stage while forwarding, free-runs while dropping.
  always_comb begin
    s_ready = '0;
    if (state == DATA) begin
      s_ready[grant] = load_ok;
    end else if (state == DROP) begin
      s_ready[grant] = 1'b1;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = m_data;
  assign m_axis.tkeep  = m_keep;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tlast  = m_last;
  assign m_axis.tdest  = '0;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= SRC_WIDTH'(PORT_COUNT - 1);
      dest_lat    <= '0;
      beat_cnt    <= '0;
      trunc_count <= '0;
      m_data      <= '0;
      m_keep      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
    end else begin
      if (m_valid && m_axis.tready) begin
        m_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            grant    <= grant_nxt;
            dest_lat <= nxt_dest;
            state    <= HDR;
          end
        end
        HDR: begin
          if (load_ok) begin
            m_data   <= hdr_data;
            m_keep   <= '1;
            m_last   <= 1'b0;
            m_valid  <= 1'b1;
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (load_ok && g_valid) begin
            m_data   <= g_data;
            m_keep   <= g_keep;
            m_valid  <= 1'b1;
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            if (g_last) begin
              m_last     <= 1'b1;
              last_grant <= grant;
              state      <= IDLE;
            end else if (beat_cnt == BEAT_LIMIT) begin
              // Over-long frame: close it here and swallow the rest of the source frame.
              m_last <= 1'b1;
              if (trunc_count != 16'hFFFF) begin
                trunc_count <= trunc_count + 16'd1;
              end
              state <= DROP;
            end else begin
              m_last <= 1'b0;
            end
          end
        end
        DROP: begin
          if (g_valid && g_last) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loopback_msg_arbiter.sv
// Scoreboard bench for loopback_msg_arbiter: per-port source queues drive the
// ingress, expected header/payload beats are queued at issue time and popped by a monitor.
module tb_loopback_msg_arbiter;
  localparam int unsigned DW   = 64;
  localparam int unsigned KW   = 8;
  localparam int unsigned PC   = 4;
  localparam int unsigned TW   = 9;
  localparam int          MAXB = 8;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [8:0]  dest;
    int          gap;
  } sbeat_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } obeat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] trunc_count;

  always #5 clk = ~clk;

  loopback_msg_arbiter_if #(.LANES(PC), .DATA_WIDTH(DW), .STRB_WIDTH(KW), .DEST_WIDTH(TW)) s_if ();
  loopback_msg_arbiter_if #(.LANES(1),  .DATA_WIDTH(DW), .STRB_WIDTH(KW), .DEST_WIDTH(TW)) m_if ();

  loopback_msg_arbiter #(.MAX_BEATS(MAXB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .busy        (busy),
    .trunc_count (trunc_count)
  );

  sbeat_t src_q [PC][$];
  obeat_t exp_q [$];
  int     gap_cnt [PC];
  bit     acc [PC];
  bit     throttle = 1'b0;
  int     errors = 0;
  int     checks = 0;
  int     xfer_count = 0;
  int     tag = 0;
  int     wait_n;
  int     xfer_base;

  logic        stall_prev = 1'b0;
  logic [63:0] d_prev;
  logic [7:0]  k_prev;
  logic        l_prev;
  obeat_t      got_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Queue one source frame and the header+payload the arbiter should emit for it.
  task automatic send_frame(input int port, input logic [8:0] dest, input int n,
                            input int gap_at, input int gap_len);
    sbeat_t b;
    obeat_t e;
    tag++;
    e.data = (64'(port) << 56) | 64'(dest);
    e.keep = 8'hFF;
    e.last = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      b.data = {16'(port), 16'(tag), 32'(i) ^ 32'hC0DE_0000};
      b.keep = (i == n - 1) ? 8'h0F : ((i % 2 == 1) ? 8'hF0 : 8'hFF);
      b.last = (i == n - 1);
      b.dest = dest;
      b.gap  = (i == gap_at) ? gap_len : 0;
      src_q[port].push_back(b);
      if (i < MAXB) begin
        e.data = b.data;
        e.keep = b.keep;
        e.last = (i == n - 1) || (i == MAXB - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk); #2;
      n++;
      done = (exp_q.size() == 0) && !busy;
      for (int p = 0; p < PC; p++) if (src_q[p].size() != 0) done = 1'b0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s drain timeout: expected beats left %0d, required 0", name, exp_q.size());
    end
  endtask

  // Source driver: present queue heads after each edge, honouring per-beat valid gaps.
  initial begin
    s_if.tvalid = '0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = '0;
    s_if.tdest  = '0;
    m_if.tready = 1'b1;
    for (int p = 0; p < PC; p++) gap_cnt[p] = 0;
    forever begin
      @(posedge clk); #1;
      for (int p = 0; p < PC; p++) begin
        if (acc[p] && src_q[p].size() > 0) begin
          src_q[p].delete(0);
          if (src_q[p].size() > 0) gap_cnt[p] = src_q[p][0].gap;
        end
        if (gap_cnt[p] > 0) begin
          s_if.tvalid[p] = 1'b0;
          gap_cnt[p]--;
        end else if (src_q[p].size() > 0) begin
          s_if.tvalid[p]            = 1'b1;
          s_if.tdata[p*DW +: DW]    = src_q[p][0].data;
          s_if.tkeep[p*KW +: KW]    = src_q[p][0].keep;
          s_if.tlast[p]             = src_q[p][0].last;
          s_if.tdest[p*TW +: TW]    = src_q[p][0].dest;
        end else begin
          s_if.tvalid[p] = 1'b0;
        end
      end
      m_if.tready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: sample on the falling edge, score transfers and check stall stability.
  initial begin
    forever begin
      @(negedge clk);
      for (int p = 0; p < PC; p++) acc[p] = s_if.tvalid[p] && s_if.tready[p];
      if (rst_n) begin
        if (stall_prev) begin
          checks++;
          if (m_if.tvalid !== 1'b1 || m_if.tdata !== d_prev || m_if.tkeep !== k_prev ||
              m_if.tlast !== l_prev) begin
            errors++;
            $display("FAIL hold_stable: got valid=%b data=%h, required valid=1 data=%h",
                     m_if.tvalid, m_if.tdata, d_prev);
          end
        end
        if (m_if.tvalid && m_if.tready) begin
          xfer_count++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got data=%h last=%b, required no beat",
                     m_if.tdata, m_if.tlast);
          end else begin
            got_e = exp_q.pop_front();
            if (m_if.tdata !== got_e.data || m_if.tkeep !== got_e.keep ||
                m_if.tlast !== got_e.last) begin
              errors++;
              $display("FAIL out_beat: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                       m_if.tdata, m_if.tkeep, m_if.tlast, got_e.data, got_e.keep, got_e.last);
            end
          end
        end
        stall_prev = m_if.tvalid && !m_if.tready;
        d_prev     = m_if.tdata;
        k_prev     = m_if.tkeep;
        l_prev     = m_if.tlast;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_s_tready", 64'(s_if.tready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_trunc", 64'(trunc_count), 64'd0);
    #2 rst_n = 1'b1;

    // Ports 0 and 2, 3-beat frames: port 0 first after reset.
    @(negedge clk); #2;
    send_frame(0, 9'h015, 3, -1, 0);
    send_frame(2, 9'h0A3, 3, -1, 0);
    wait_drain("two_ports", 200);

    // All ports, 1-beat frames, two each; rotation continues after port 2.
    @(negedge clk); #2;
    for (int r = 0; r < 2; r++) begin
      send_frame(3, 9'(9'h100 + r), 1, -1, 0);
      send_frame(0, 9'(9'h010 + r), 1, -1, 0);
      send_frame(1, 9'(9'h020 + r), 1, -1, 0);
      send_frame(2, 9'(9'h030 + r), 1, -1, 0);
    end
    wait_drain("round_robin", 300);

    // 14-beat frame on port 1 truncated to MAXB, then port 2 follows.
    @(negedge clk); #2;
    send_frame(1, 9'h1FF, 14, -1, 0);
    send_frame(2, 9'h000, 1, -1, 0);
    wait_drain("truncate", 300);
    check("trunc_count_1", 64'(trunc_count), 64'd1);

    // Throttled output: exactly-MAXB frame on port 3 (not truncated), then port 0.
    @(negedge clk); #2;
    throttle = 1'b1;
    send_frame(3, 9'h0C7, MAXB, -1, 0);
    send_frame(0, 9'h044, 5, -1, 0);
    wait_drain("throttle", 600);
    throttle = 1'b0;
    check("trunc_count_exact", 64'(trunc_count), 64'd1);

    // Port 1 stalls 5 cycles mid-frame while port 3 waits; no switch.
    @(negedge clk); #2;
    send_frame(1, 9'h0B1, 4, 2, 5);
    send_frame(3, 9'h033, 2, -1, 0);
    wait_drain("stall", 300);

    // Reset in the middle of a port-2 frame.
    @(negedge clk); #2;
    send_frame(2, 9'h055, 6, -1, 0);
    xfer_base = xfer_count;
    wait_n = 0;
    while (xfer_count < xfer_base + 3 && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    check("mid_frame_reached", 64'(xfer_count >= xfer_base + 3), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("mid_rst_s_tready", 64'(s_if.tready), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_trunc", 64'(trunc_count), 64'd0);
    for (int p = 0; p < PC; p++) begin
      src_q[p].delete();
      gap_cnt[p] = 0;
      acc[p] = 1'b0;
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // After reset port 0 wins over port 3 again.
    @(negedge clk); #2;
    send_frame(0, 9'h0E0, 1, -1, 0);
    send_frame(3, 9'h0E3, 1, -1, 0);
    wait_drain("post_reset", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
